baud_rate_gen: RTL and testbench

Parametrised successor to the fixed 50 MHz / 9600 baud enable generator for the UART-IrDA path. It produces three outputs:
- an oversampling tick (os_tick) for the RX sampler;
- a bit tick (bit_tick) for TX;
- an IrDA pulse window (irda_pulse) for the IrDA encoder.

The divisor is loadable at runtime, and the bit phase can be restarted so RX aligns to a start-bit edge. Sits between the system clock and the uart_tx, uart_rx and irda_enc blocks.

---
 rtl/baud_rate_gen_if.sv | 40 ++++
 rtl/baud_rate_gen.sv | 119 +++++++++++
 tb/tb_baud_rate_gen.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/baud_rate_gen_if.sv
// Control and tick bundle between baud_rate_gen and the UART/IrDA blocks.
// frac_in exists only when BAUD_FRAC_EN is defined.
interface baud_rate_gen_if #(
  parameter int DIV_W = 16,
  parameter int PH_W  = 4
);
  // div_load and restart are single-cycle strobes sampled on the rising clock
  // edge; there is no ready, the generator always accepts them.
  logic             enable;
  logic             div_load;
  logic [DIV_W-1:0] div_in;
  logic             restart;
`ifdef BAUD_FRAC_EN
  logic [3:0]       frac_in;
`endif
  logic             os_tick;
  logic             bit_tick;
  logic             irda_pulse;
  logic [PH_W-1:0]  os_phase;

`ifdef BAUD_FRAC_EN
  modport master (
    output enable, div_load, div_in, restart, frac_in,
    input  os_tick, bit_tick, irda_pulse, os_phase
  );
  modport slave (
    input  enable, div_load, div_in, restart, frac_in,
    output os_tick, bit_tick, irda_pulse, os_phase
  );
`else
  modport master (
    output enable, div_load, div_in, restart,
    input  os_tick, bit_tick, irda_pulse, os_phase
  );
  modport slave (
    input  enable, div_load, div_in, restart,
    output os_tick, bit_tick, irda_pulse, os_phase
  );
`endif
endinterface

// File: rtl/baud_rate_gen.sv
// Loadable-divisor baud enable generator: os_tick, bit_tick, irda_pulse, os_phase.
// Optional fractional divisor when BAUD_FRAC_EN is defined.
module baud_rate_gen #(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_W       = 16,
  parameter int IRDA_PULSE  = 3,
  parameter int DEFAULT_DIV = CLK_HZ / (BAUD * OVERSAMPLE)
) (
  input logic            clock,
  input logic            reset,
  baud_rate_gen_if.slave bus
);
  localparam int PH_W = $clog2(OVERSAMPLE);

  typedef logic [PH_W-1:0]  ph_t;
  typedef logic [DIV_W-1:0] div_t;

  localparam ph_t  LAST_PH = ph_t'(OVERSAMPLE - 1);
  localparam ph_t  IRDA_TH = ph_t'(IRDA_PULSE);
  localparam div_t MIN_DIV = div_t'(2);
  localparam div_t RST_DIV = div_t'(DEFAULT_DIV);

  div_t div_q, div_d;
  div_t cnt_q, cnt_d;
  ph_t  phase_q, phase_d;
  logic os_q, os_d;
  logic bit_q, bit_d;
  logic irda_q, irda_d;
  logic ext;
  logic at_term;
  logic [DIV_W:0] term_cnt;

`ifdef BAUD_FRAC_EN
  logic [3:0] frac_q, frac_d;
  logic [3:0] acc_q, acc_d;
  logic       ext_q, ext_d;
  logic [4:0] acc_sum;
  assign ext = ext_q;
`else
  assign ext = 1'b0;
`endif

  // One extra bit so a stretched period (div+1) never wraps the compare value.
  assign term_cnt = {1'b0, div_q} - {{DIV_W{1'b0}}, 1'b1} + {{DIV_W{1'b0}}, ext};
  assign at_term  = ({1'b0, cnt_q} == term_cnt);

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    os_d    = 1'b0;
    bit_d   = 1'b0;
    irda_d  = bus.enable && (phase_q < IRDA_TH);
`ifdef BAUD_FRAC_EN
    frac_d  = frac_q;
    acc_d   = acc_q;
    ext_d   = ext_q;
    acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
`endif
    if (bus.restart || bus.div_load) begin
      cnt_d = '0;
      if (bus.div_load) div_d = (bus.div_in < MIN_DIV) ? MIN_DIV : bus.div_in;
      if (bus.restart)  phase_d = '0;
`ifdef BAUD_FRAC_EN
      acc_d = '0;
      ext_d = 1'b0;
      if (bus.div_load) frac_d = bus.frac_in;
`endif
    end else if (bus.enable) begin
      if (at_term) begin
        cnt_d   = '0;
        os_d    = 1'b1;
        bit_d   = (phase_q == LAST_PH);
        phase_d = phase_q + ph_t'(1);
`ifdef BAUD_FRAC_EN
        acc_d = acc_sum[3:0];
        ext_d = acc_sum[4];
`endif
      end else begin
        cnt_d = cnt_q + div_t'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q   <= RST_DIV;
      cnt_q   <= '0;
      phase_q <= '0;
      os_q    <= 1'b0;
      bit_q   <= 1'b0;
      irda_q  <= 1'b0;
`ifdef BAUD_FRAC_EN
      frac_q  <= '0;
      acc_q   <= '0;
      ext_q   <= 1'b0;
`endif
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      irda_q  <= irda_d;
`ifdef BAUD_FRAC_EN
      frac_q  <= frac_d;
      acc_q   <= acc_d;
      ext_q   <= ext_d;
`endif
    end
  end

  assign bus.os_tick    = os_q;
  assign bus.bit_tick   = bit_q;
  assign bus.irda_pulse = irda_q;
  assign bus.os_phase   = phase_q;
endmodule

// File: tb/tb_baud_rate_gen.sv
// Bench for baud_rate_gen: vector table, directed corner sequences and a
// randomized run against an arithmetic reference model.
module tb_baud_rate_gen;
  localparam int DIV_W   = 16;
  localparam int OS      = 16;
  localparam int PH_W    = 4;
  localparam int IRDA    = 3;
  localparam int DEF_DIV = 325;
  localparam int W       = 3 + PH_W;
  localparam int NVEC    = 19;

  typedef struct {
    logic             en;
    logic             rs;
    logic             ld;
    logic [DIV_W-1:0] din;
    logic             os;
    logic             bt;
    logic             ir;
    logic [PH_W-1:0]  ph;
  } vec_t;

  logic clock;
  logic reset;

  baud_rate_gen_if #(.DIV_W(DIV_W), .PH_W(PH_W)) bus ();

  baud_rate_gen #(
    .CLK_HZ(50000000), .BAUD(9600), .OVERSAMPLE(OS),
    .DIV_W(DIV_W), .IRDA_PULSE(IRDA)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  vec_t tbl[NVEC];

  // Reference model: enabled counting cycles since the last alignment point.
  int   m_div, m_t, m_base;
  logic model_on;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] outs();
    return {bus.os_tick, bus.bit_tick, bus.irda_pulse, bus.os_phase};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic rs, input logic ld, input logic [DIV_W-1:0] din);
    bus.enable   = en;
    bus.restart  = rs;
    bus.div_load = ld;
    bus.div_in   = din;
  endtask

  task automatic model_reset();
    m_div    = DEF_DIV;
    m_t      = 0;
    m_base   = 0;
    model_on = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_step();
    int ph_b;
    int ph_a;
    logic os;
    logic bt;
    logic ir;
    logic [PH_W-1:0] ph;
    ph_b = (m_base + m_t / m_div) % OS;
    ir   = bus.enable && (ph_b < IRDA);
    os   = 1'b0;
    bt   = 1'b0;
    if (bus.restart || bus.div_load) begin
      if (bus.div_load) m_div = (int'(bus.div_in) < 2) ? 2 : int'(bus.div_in);
      m_base = bus.restart ? 0 : ph_b;
      m_t    = 0;
    end else if (bus.enable) begin
      m_t++;
      os = (m_t % m_div) == 0;
      bt = os && (((m_base + m_t / m_div) % OS) == 0);
    end
    ph_a = (m_base + m_t / m_div) % OS;
    ph   = ph_a[PH_W-1:0];
    exp_q.push_back({os, bt, ir, ph});
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    logic [W-1:0] e;
    if (model_on) model_step();
    @(posedge clock);
    #1;
    if (model_on) begin
      e = exp_q.pop_front();
      check("model", 32'(outs()), 32'(e));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", 32'(outs()), 32'd0);
    reset = 1'b1;
    model_reset();
  endtask

  // sel 0 waits for os_tick, sel 1 for bit_tick; n = edges taken.
  task automatic wait_sig(input int sel, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!((sel == 0) ? bus.os_tick : bus.bit_tick) && n < limit);
  endtask

  task automatic set_row(input int i, input logic en, input logic rs, input logic ld,
                         input int din, input logic os, input logic bt, input logic ir, input int ph);
    tbl[i].en  = en;
    tbl[i].rs  = rs;
    tbl[i].ld  = ld;
    tbl[i].din = DIV_W'(din);
    tbl[i].os  = os;
    tbl[i].bt  = bt;
    tbl[i].ir  = ir;
    tbl[i].ph  = PH_W'(ph);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int first_os, first_bit, os_cnt, os_at_bit, irda_cnt;
    logic [PH_W-1:0] ph_hold;
    logic found;

    reset    = 1'b0;
    model_on = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
`ifdef BAUD_FRAC_EN
    bus.frac_in = 4'd0;
`endif

    // Vector table: clamp of div_in 1 and 0 to 2, enable gap, restart, combined load+restart.
    set_row(0,  1, 0, 1, 1, 0, 0, 1, 0);
    set_row(1,  1, 0, 0, 0, 0, 0, 1, 0);
    set_row(2,  1, 0, 0, 0, 1, 0, 1, 1);
    set_row(3,  1, 0, 0, 0, 0, 0, 1, 1);
    set_row(4,  1, 0, 0, 0, 1, 0, 1, 2);
    set_row(5,  0, 0, 0, 0, 0, 0, 0, 2);
    set_row(6,  1, 0, 0, 0, 0, 0, 1, 2);
    set_row(7,  1, 0, 0, 0, 1, 0, 1, 3);
    set_row(8,  1, 0, 0, 0, 0, 0, 0, 3);
    set_row(9,  1, 1, 0, 0, 0, 0, 0, 0);
    set_row(10, 1, 0, 0, 0, 0, 0, 1, 0);
    set_row(11, 1, 0, 0, 0, 1, 0, 1, 1);
    set_row(12, 1, 0, 1, 0, 0, 0, 1, 1);
    set_row(13, 1, 0, 0, 0, 0, 0, 1, 1);
    set_row(14, 1, 0, 0, 0, 1, 0, 1, 2);
    set_row(15, 1, 1, 1, 3, 0, 0, 1, 0);
    set_row(16, 1, 0, 0, 0, 0, 0, 1, 0);
    set_row(17, 1, 0, 0, 0, 0, 0, 1, 0);
    set_row(18, 1, 0, 0, 0, 1, 0, 1, 1);

    // Defaults: os every 325, bit at 5200 on the 16th os, irda 975 clocks.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    first_os = -1; first_bit = -1; os_cnt = 0; os_at_bit = -1; irda_cnt = 0;
    for (int e = 1; e <= 5200; e++) begin
      tick();
      if (bus.os_tick) begin
        os_cnt++;
        if (first_os < 0) first_os = e;
      end
      if (bus.irda_pulse) irda_cnt++;
      if (bus.bit_tick && first_bit < 0) begin
        first_bit = e;
        os_at_bit = os_cnt;
        check("bit_with_os", 32'(bus.os_tick), 32'd1);
      end
    end
    check("first_os", 32'(first_os), 32'd325);
    check("first_bit", 32'(first_bit), 32'd5200);
    check("os_per_bit", 32'(os_at_bit), 32'd16);
    check("irda_len", 32'(irda_cnt), 32'd975);

    // div_load 4: first os 4 clocks after the load, bit period 64.
    drive(1'b1, 1'b0, 1'b1, 16'd4);
    tick();
    check("load_no_tick", 32'(bus.os_tick), 32'd0);
    drive(1'b1, 1'b0, 1'b0, '0);
    wait_sig(0, 20, n);
    check("load_os_delay", 32'(n), 32'd4);
    wait_sig(1, 200, n);
    wait_sig(1, 200, n);
    check("bit_period", 32'(n), 32'd64);

    // Restart at phase 9.
    n = 0;
    while (bus.os_phase != PH_W'(9) && n < 200) begin
      tick();
      n++;
    end
    check("find_ph9", 32'(bus.os_phase), 32'd9);
    drive(1'b1, 1'b1, 1'b0, '0);
    tick();
    check("restart_outs", 32'({bus.os_tick, bus.bit_tick, bus.os_phase}), 32'd0);
    drive(1'b1, 1'b0, 1'b0, '0);
    wait_sig(1, 200, n);
    check("restart_bit", 32'(n), 32'd64);

    // Enable gap of 10 clocks mid-period.
    wait_sig(0, 20, n);
    tick();
    tick();
    ph_hold = bus.os_phase;
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("gap_no_tick", 32'({bus.os_tick, bus.bit_tick, bus.irda_pulse}), 32'd0);
    end
    check("gap_phase", 32'(bus.os_phase), 32'(ph_hold));
    drive(1'b1, 1'b0, 1'b0, '0);
    wait_sig(0, 20, n);
    check("gap_os_delay", 32'(n + 12), 32'd14);

    // Asynchronous reset between edges while os_tick=1 and phase=7.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = (bus.os_phase == PH_W'(7)) && bus.os_tick;
    end
    check("find_ph7", 32'(found), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", 32'(outs()), 32'd0);
    model_on = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    wait_sig(0, 400, n);
    check("post_reset_os", 32'(n), 32'd325);

    // Vector table.
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].en, tbl[i].rs, tbl[i].ld, tbl[i].din);
      tick();
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({tbl[i].os, tbl[i].bt, tbl[i].ir, tbl[i].ph}));
    end

    // Randomized run against the model.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 16'd4);
    tick();
    for (int i = 0; i < 4000; i++) begin
      logic en;
      en = ($urandom_range(0, 9) != 0);
      drive(en, ($urandom_range(0, 99) < 2), en && ($urandom_range(0, 199) < 3),
            DIV_W'($urandom_range(0, 6)));
      tick();
    end

`ifdef BAUD_FRAC_EN
    // Fractional divisor 4 + 8/16: steady-state periods alternate, 72 clocks per bit.
    begin
      int t[20];
      int e;
      int k;
      model_on = 1'b0;
      bus.frac_in = 4'd8;
      drive(1'b1, 1'b1, 1'b1, 16'd4);
      tick();
      bus.frac_in = 4'd0;
      drive(1'b1, 1'b0, 1'b0, '0);
      e = 0;
      k = 0;
      while (k < 20 && e < 400) begin
        tick();
        e++;
        if (bus.os_tick) begin
          t[k] = e;
          k++;
        end
      end
      check("frac_ticks", 32'(k), 32'd20);
      check("frac_bit_len", 32'(t[17] - t[1]), 32'd72);
      for (int i = 2; i < 18; i++)
        check("frac_alt", 32'(t[i + 1] - t[i - 1]), 32'd9);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
